commit_trace_packer: RTL and testbench
======================================

Name: commit_trace_packer

Overview:
- DUT-side producer of per-hart retirement records for the cosim checker; the upstream end of the commit/judge/trap stream.
- Captures up to COMMITS retire slots plus one trap event per cycle and orders them into a FIFO.
- Emits one record per cycle over a valid/ready interface, so a checker can consume a multi-issue core one instruction at a time.

Parameters:
- COMMITS, 2, retire slots per cycle; slot 0 is oldest.
- DEPTH, 16, FIFO entries; power of two, at least COMMITS+1.
- HARTID, 0, constant driven on out_hartid.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- slot_valid  in  COMMITS  slot i retired this cycle
- slot_pc  in  64*COMMITS  retired pc, slot i at bits [64i+63:64i]
- slot_insn  in  32*COMMITS  retired instruction
- slot_wen  in  COMMITS  slot wrote an integer register
- slot_waddr  in  5*COMMITS  destination register
- slot_wdata  in  64*COMMITS  written value
- trap_valid  in  1  trap taken this cycle; logically after all valid slots
- trap_cause  in  64  mcause value
- in_ready  out  1  free entries >= COMMITS+1
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts
- out_kind  out  2  0 = commit, no write; 1 = commit with write; 2 = trap; 3 unused
- out_pc  out  64  pc; 0 for trap
- out_insn  out  32  insn; 0 for trap
- out_waddr  out  5  0 unless kind 1
- out_wdata  out  64  wdata for kind 1; cause for kind 2
- out_seq  out  32  record sequence number
- out_hartid  out  32  HARTID
- overflow  out  1  sticky; a batch was dropped

Behaviour:
- Reset (synchronous, active-high):
  - Pointers, count, sequence counter and overflow clear to 0.
  - All out_* fields read 0; out_valid = 0; in_ready = 1.
  - Reset mid-stream discards all entries.
- Batch:
  - The batch is the valid slots in ascending index order, then the trap if trap_valid.
  - Slots with slot_valid = 0 are skipped. Entries are written compacted, with no holes.
  - Batch size n is 0..COMMITS+1.
- Push rule:
  - The whole batch is written in one cycle if count - pop + n <= DEPTH, where pop is this cycle's out_valid && out_ready.
  - Otherwise the whole batch is dropped (never partial), overflow is set, and it stays set until reset.
- Sequence numbers:
  - out_seq is assigned at push as seq, seq+1, ... in batch order; seq advances by n.
  - Wraps modulo 2^32.
  - Dropped batches do not advance seq, so the checker detects a loss via the overflow flag only.
- Output:
  - FIFO-head record, registered from storage.
  - Latency: a record pushed in cycle t is visible at the head at t+1 at the earliest, when the FIFO was empty.
- Handshake:
  - out_valid = count != 0. Pop occurs on out_valid && out_ready.
  - While out_valid && !out_ready, all out_* fields are held stable.
  - out_valid never deasserts without a pop.
- Simultaneous push and pop:
  - count_next = count + n - pop.
  - Full FIFO plus pop frees 1 entry for that cycle's push check.
- Pointers: wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide.
- in_ready:
  - Combinational from registered count only; it does not depend on this cycle's pop.
  - The core is expected to stall retire when in_ready = 0; ignoring it leads to drop semantics.
- slot_wen with slot_waddr = 0 emits kind 0.

Optional Feature:
- TRACE_TIMESTAMP_EN defined:
  - Adds an output port out_time, 64 bits.
  - A free-running cycle counter resets to 0 and increments every non-reset cycle.
  - Its value at push is stored per entry; all records of one batch share the same time.
- TRACE_TIMESTAMP_EN undefined: no counter, no port, no storage.

Test Plan:
- Reset release, no events -> out_valid = 0, in_ready = 1, overflow = 0, out_seq = 0.
- Single batch:
  - Stimulus: one cycle with slot0 {pc 0x80000000, insn 0x00000013, wen 0} and slot1 {pc 0x80000004, insn 0x00a00093, wen 1, waddr 1, wdata 0xa}; out_ready = 1.
  - Expected: kind 0 with seq 0, then kind 1 with seq 1 and wdata 0xa, on consecutive cycles.
- Slot compaction and trap ordering:
  - Stimulus: slot0 invalid, slot1 valid pc 0x80000010, trap_valid with cause 0x8.
  - Expected: commit at 0x80000010, then trap with out_wdata 0x8 and out_pc 0; seq values consecutive.
- Backpressure:
  - Stimulus: out_ready = 0 for 20 cycles while 2 commits/cycle are driven.
  - Expected: in_ready drops at count >= 14, head fields are held stable, and the first dropped batch sets overflow.
  - Then release out_ready: the 16 stored records drain in order, with seq contiguous 0..15.
- Full plus simultaneous push/pop:
  - Stimulus: count 15, pop asserted, 2-entry batch.
  - Expected: batch accepted, count 16, overflow unchanged.
- Reset asserted with 5 entries queued -> next cycle out_valid = 0 and overflow = 0; the first new record has seq 0 (and out_time restarts at 0 under TRACE_TIMESTAMP_EN).

Source files
------------

// File: rtl/commit_trace_packer_if.sv
// Commit/trap trace bus between a retiring core, the trace packer and the cosim checker.
// TRACE_TIMESTAMP_EN adds the out_time field.
interface commit_trace_packer_if #(
    parameter int unsigned COMMITS = 2
);
    logic [COMMITS-1:0]    slot_valid;
    logic [64*COMMITS-1:0] slot_pc;
    logic [32*COMMITS-1:0] slot_insn;
    logic [COMMITS-1:0]    slot_wen;
    logic [5*COMMITS-1:0]  slot_waddr;
    logic [64*COMMITS-1:0] slot_wdata;
    logic                  trap_valid;
    logic [63:0]           trap_cause;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            out_kind;
    logic [63:0]           out_pc;
    logic [31:0]           out_insn;
    logic [4:0]            out_waddr;
    logic [63:0]           out_wdata;
    logic [31:0]           out_seq;
    logic [31:0]           out_hartid;
    logic                  overflow;
`ifdef TRACE_TIMESTAMP_EN
    logic [63:0]           out_time;
`endif

    // Packer side.
    modport master (
        input  slot_valid, slot_pc, slot_insn, slot_wen, slot_waddr, slot_wdata,
        input  trap_valid, trap_cause, out_ready,
`ifdef TRACE_TIMESTAMP_EN
        output out_time,
`endif
        output in_ready, out_valid, out_kind, out_pc, out_insn, out_waddr,
        output out_wdata, out_seq, out_hartid, overflow
    );

    // Core/checker side.
    modport slave (
        output slot_valid, slot_pc, slot_insn, slot_wen, slot_waddr, slot_wdata,
        output trap_valid, trap_cause, out_ready,
`ifdef TRACE_TIMESTAMP_EN
        input  out_time,
`endif
        input  in_ready, out_valid, out_kind, out_pc, out_insn, out_waddr,
        input  out_wdata, out_seq, out_hartid, overflow
    );
endinterface

// File: rtl/commit_trace_packer.sv
// Packs up to COMMITS retire slots plus one trap per cycle into a FIFO of sequenced records.
// Optional TRACE_TIMESTAMP_EN stamps every record with a free-running cycle count.
module commit_trace_packer #(
    parameter int unsigned COMMITS = 2,
    parameter int unsigned DEPTH   = 16,
    parameter logic [31:0] HARTID  = 32'd0
) (
    input  logic                  clock,
    input  logic                  reset,
    commit_trace_packer_if.master trace
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned LW = CW + 1;
    localparam int unsigned NB = COMMITS + 1;
    localparam int unsigned NW = $clog2(NB + 1);

    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] pc;
        logic [31:0] insn;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic [31:0] seq;
`ifdef TRACE_TIMESTAMP_EN
        logic [63:0] stamp;
`endif
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_seq;
    logic          r_overflow;
`ifdef TRACE_TIMESTAMP_EN
    logic [63:0]   r_time;
`endif

    entry_t        w_batch [NB];
    logic [NW-1:0] w_n;
    logic          w_pop;
    logic [LW-1:0] w_level;
    logic          w_accept;
    entry_t        w_head;

    // Compact valid slots (oldest first), trap last; each entry gets its final seq here.
    always_comb begin
        w_n = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            w_batch[k] = '0;
        end
        for (int unsigned i = 0; i < COMMITS; i++) begin
            if (trace.slot_valid[i]) begin
                w_batch[w_n].pc   = trace.slot_pc[64*i +: 64];
                w_batch[w_n].insn = trace.slot_insn[32*i +: 32];
                w_batch[w_n].seq  = r_seq + 32'(w_n);
`ifdef TRACE_TIMESTAMP_EN
                w_batch[w_n].stamp = r_time;
`endif
                if (trace.slot_wen[i] && (trace.slot_waddr[5*i +: 5] != 5'd0)) begin
                    w_batch[w_n].kind  = 2'd1;
                    w_batch[w_n].waddr = trace.slot_waddr[5*i +: 5];
                    w_batch[w_n].wdata = trace.slot_wdata[64*i +: 64];
                end
                w_n = w_n + 1'b1;
            end
        end
        if (trace.trap_valid) begin
            w_batch[w_n].kind  = 2'd2;
            w_batch[w_n].wdata = trace.trap_cause;
            w_batch[w_n].seq   = r_seq + 32'(w_n);
`ifdef TRACE_TIMESTAMP_EN
            w_batch[w_n].stamp = r_time;
`endif
            w_n = w_n + 1'b1;
        end
    end

    // A same-cycle pop frees its slot for this cycle's all-or-nothing push check.
    assign w_pop    = (r_count != '0) && trace.out_ready;
    assign w_level  = LW'(r_count) - LW'(w_pop) + LW'(w_n);
    assign w_accept = (w_level <= LW'(DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(w_n);
                r_seq    <= r_seq + 32'(w_n);
                r_count  <= CW'(w_level);
            end else begin
                r_overflow <= 1'b1;
                r_count    <= r_count - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_accept) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (k < 32'(w_n)) begin
                    r_mem[r_wr_ptr + AW'(k)] <= w_batch[k];
                end
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_time <= '0;
        end else begin
            r_time <= r_time + 64'd1;
        end
    end
`endif

    // Head read straight from storage; zeroed while empty so stale entries never show.
    assign w_head = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

    assign trace.out_valid  = (r_count != '0);
    assign trace.in_ready   = ((CW'(DEPTH) - r_count) >= CW'(NB));
    assign trace.out_kind   = w_head.kind;
    assign trace.out_pc     = w_head.pc;
    assign trace.out_insn   = w_head.insn;
    assign trace.out_waddr  = w_head.waddr;
    assign trace.out_wdata  = w_head.wdata;
    assign trace.out_seq    = w_head.seq;
    assign trace.out_hartid = HARTID;
    assign trace.overflow   = r_overflow;
`ifdef TRACE_TIMESTAMP_EN
    assign trace.out_time   = w_head.stamp;
`endif
endmodule

// File: tb/tb_commit_trace_packer.sv
// Scoreboard bench for commit_trace_packer: expected records queued at push, compared at the head.
// Also checks out_time when TRACE_TIMESTAMP_EN is defined.
module tb_commit_trace_packer;
    localparam int unsigned COMMITS = 2;
    localparam int unsigned DEPTH   = 16;

    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] pc;
        logic [31:0] insn;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic [31:0] seq;
        logic [63:0] stamp;
    } rec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    commit_trace_packer_if #(.COMMITS(COMMITS)) trace ();

    commit_trace_packer #(
        .COMMITS(COMMITS),
        .DEPTH  (DEPTH),
        .HARTID (32'd0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .trace(trace)
    );

    int          checks   = 0;
    int          failures = 0;
    rec_t        q[$];
    int unsigned m_count  = 0;
    logic [31:0] m_seq    = '0;
    logic        m_ovf    = 1'b0;
    logic [63:0] m_time   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        trace.slot_valid = '0;
        trace.slot_wen   = '0;
        trace.trap_valid = 1'b0;
    endtask

    task automatic set_slot(input int unsigned i, input logic [63:0] pc, input logic [31:0] insn,
                            input logic wen, input logic [4:0] waddr, input logic [63:0] wdata);
        trace.slot_valid[i]          = 1'b1;
        trace.slot_pc[64*i +: 64]    = pc;
        trace.slot_insn[32*i +: 32]  = insn;
        trace.slot_wen[i]            = wen;
        trace.slot_waddr[5*i +: 5]   = waddr;
        trace.slot_wdata[64*i +: 64] = wdata;
    endtask

    task automatic push_pair(input int unsigned c);
        set_slot(0, 64'h8000_1000 + 64'(8*c), 32'h0000_0013, 1'b1, 5'(c + 1), 64'(c * 3));
        set_slot(1, 64'h8000_1004 + 64'(8*c), 32'h0010_0093, 1'b1, 5'(c + 2), 64'(c * 5 + 1));
    endtask

    task automatic check_outputs();
        rec_t e;
        chk("out_valid", 64'(trace.out_valid), 64'(m_count != 0));
        chk("in_ready", 64'(trace.in_ready), 64'((DEPTH - m_count) >= COMMITS + 1));
        chk("overflow", 64'(trace.overflow), 64'(m_ovf));
        chk("hartid", 64'(trace.out_hartid), 64'd0);
        e = (m_count != 0) ? q[0] : '0;
        chk("kind", 64'(trace.out_kind), 64'(e.kind));
        chk("pc", trace.out_pc, e.pc);
        chk("insn", 64'(trace.out_insn), 64'(e.insn));
        chk("waddr", 64'(trace.out_waddr), 64'(e.waddr));
        chk("wdata", trace.out_wdata, e.wdata);
        chk("seq", 64'(trace.out_seq), 64'(e.seq));
`ifdef TRACE_TIMESTAMP_EN
        chk("time", trace.out_time, e.stamp);
`endif
    endtask

    // One clock: compare the head before the edge, then apply this cycle's pop/push to the model.
    task automatic step();
        rec_t        b[$];
        rec_t        r;
        int unsigned pop;
        @(negedge clock);
        if (reset) begin
            q.delete();
            m_count = 0;
            m_seq   = '0;
            m_ovf   = 1'b0;
            m_time  = '0;
        end else begin
            check_outputs();
            pop = ((m_count != 0) && trace.out_ready) ? 1 : 0;
            if (pop == 1) void'(q.pop_front());
            for (int i = 0; i < COMMITS; i++) begin
                if (trace.slot_valid[i]) begin
                    r       = '0;
                    r.pc    = trace.slot_pc[64*i +: 64];
                    r.insn  = trace.slot_insn[32*i +: 32];
                    r.stamp = m_time;
                    if (trace.slot_wen[i] && trace.slot_waddr[5*i +: 5] != 5'd0) begin
                        r.kind  = 2'd1;
                        r.waddr = trace.slot_waddr[5*i +: 5];
                        r.wdata = trace.slot_wdata[64*i +: 64];
                    end
                    b.push_back(r);
                end
            end
            if (trace.trap_valid) begin
                r       = '0;
                r.kind  = 2'd2;
                r.wdata = trace.trap_cause;
                r.stamp = m_time;
                b.push_back(r);
            end
            if (m_count - pop + b.size() <= DEPTH) begin
                foreach (b[k]) begin
                    b[k].seq = m_seq + 32'(k);
                    q.push_back(b[k]);
                end
                m_seq   = m_seq + 32'(b.size());
                m_count = m_count - pop + b.size();
            end else begin
                m_ovf   = 1'b1;
                m_count = m_count - pop;
            end
            m_time = m_time + 64'd1;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        trace.slot_pc    = '0;
        trace.slot_insn  = '0;
        trace.slot_waddr = '0;
        trace.slot_wdata = '0;
        trace.trap_cause = '0;
        trace.out_ready  = 1'b1;
        idle();

        // reset release, idle
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step(); step();

        // single two-slot batch
        set_slot(0, 64'h8000_0000, 32'h0000_0013, 1'b0, 5'd0, 64'h0);
        set_slot(1, 64'h8000_0004, 32'h00a0_0093, 1'b1, 5'd1, 64'ha);
        step();
        idle();
        repeat (4) step();

        // slot 0 skipped, trap ordered after the commit
        set_slot(1, 64'h8000_0010, 32'h0000_0073, 1'b0, 5'd0, 64'h0);
        trace.trap_valid = 1'b1;
        trace.trap_cause = 64'h8;
        step();
        idle();
        repeat (4) step();

        // write to x0 reports as a plain commit
        set_slot(0, 64'h8000_0020, 32'h0550_0013, 1'b1, 5'd0, 64'h55);
        step();
        idle();
        repeat (3) step();

        // full FIFO with a same-cycle pop accepts a 2-entry batch
        reset = 1'b1; step(); reset = 1'b0;
        trace.out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            push_pair(c);
            step();
        end
        idle();
        trace.out_ready = 1'b1;
        step();
        push_pair(8);
        step();
        idle();
        chk("full_pushpop_ovf", 64'(trace.overflow), 64'd0);
        chk("full_pushpop_valid", 64'(trace.out_valid), 64'd1);
        repeat (20) step();

        // backpressure: 20 cycles stalled, drops set overflow, then drain seq 0..15
        reset = 1'b1; step(); reset = 1'b0;
        trace.out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            push_pair(c);
            step();
        end
        idle();
        step();
        trace.out_ready = 1'b1;
        repeat (20) step();

        // reset with 5 queued entries and overflow set
        trace.out_ready = 1'b0;
        push_pair(30); step();
        push_pair(31); step();
        idle();
        set_slot(0, 64'h8000_2000, 32'h0000_0013, 1'b0, 5'd0, 64'h0);
        step();
        idle();
        reset = 1'b1; step(); reset = 1'b0;
        trace.out_ready = 1'b1;
        step();
        set_slot(1, 64'h8000_3000, 32'h0070_0393, 1'b1, 5'd7, 64'h1234);
        step();
        idle();
        repeat (3) step();

        // random retire/trap/ready mix
        for (int c = 0; c < 60; c++) begin
            idle();
            for (int i = 0; i < COMMITS; i++) begin
                if ($urandom_range(1, 0) == 1) begin
                    set_slot(i, {32'h0, $urandom()}, $urandom(), 1'($urandom_range(1, 0)),
                             5'($urandom_range(31, 0)), {$urandom(), $urandom()});
                end
            end
            trace.trap_valid = ($urandom_range(7, 0) == 0);
            trace.trap_cause = 64'($urandom_range(15, 0));
            trace.out_ready  = ($urandom_range(3, 0) != 0);
            step();
        end
        idle();
        trace.out_ready = 1'b1;
        repeat (24) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
